// File: rtl/crf_lite_master.sv
// AXI4-Lite initiator for the config register file. Takes one command at a
// time (write / read / wait-for-interrupt), runs the AXI-Lite handshakes,
// and returns a single response. A per-command timeout aborts a hung slave
// and latches a sticky hung flag that blocks further commands until reset.
//
// Handshake semantics (all channels, command and response ports included):
// a transfer happens on a rising clk edge where valid & ready are both 1.
// A raised valid stays high with stable payload until its transfer; it is
// only withdrawn early by a timeout abort or by rst. A ready never depends
// combinationally on the valid it pairs with.
module crf_lite_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  // command port
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  // response port
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          hung,
  // write address channel
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  // write data channel
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  // write response channel
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  // read address channel
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  // read data channel
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  // interrupt from the CRF (level)
  input  logic                          interrupt_updone,
  // FSM state for debug / checkers
  output logic [2:0]                    state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_WR_RESP  = 3'd2,
    S_RD_ADDR  = 3'd3,
    S_RD_DATA  = 3'd4,
    S_WAIT_IRQ = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q;
  logic [AXI_DATA_WIDTH-1:0]  wdata_q;
  logic                       aw_pend_q, w_pend_q;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q;
  logic [1:0]                 resp_q;
  logic                       timeout_q;
  logic                       hung_q;

  logic accept;
  logic busy;
  logic cnt_hit;
  logic wr_done;
  logic timeout_fire;

  assign accept  = cmd_valid & cmd_ready;
  assign busy    = (state_q == S_WR) || (state_q == S_WR_RESP) || (state_q == S_RD_ADDR) ||
                   (state_q == S_RD_DATA) || (state_q == S_WAIT_IRQ);
  assign cnt_hit = busy && (cnt_q == CNT_LAST);
  // Both write-side handshakes finished by the end of this cycle (either may
  // already be done, or land now).
  assign wr_done = (~aw_pend_q | m_axi_awready) & (~w_pend_q | m_axi_wready);

  // Next-state logic; only a final-phase completion beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00:   state_d = S_WR;
            2'b01:   state_d = S_RD_ADDR;
            2'b10:   state_d = S_WAIT_IRQ;
            default: state_d = S_RESP;
          endcase
        end
      end
      S_WR: begin
        if (cnt_hit) begin
          state_d      = S_RESP;
          timeout_fire = 1'b1;
        end else if (wr_done) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d = S_RESP;
        end else if (cnt_hit) begin
          state_d      = S_RESP;
          timeout_fire = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (cnt_hit) begin
          state_d      = S_RESP;
          timeout_fire = 1'b1;
        end else if (m_axi_arready) begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          state_d = S_RESP;
        end else if (cnt_hit) begin
          state_d      = S_RESP;
          timeout_fire = 1'b1;
        end
      end
      S_WAIT_IRQ: begin
        if (interrupt_updone) begin
          state_d = S_RESP;
        end else if (cnt_hit) begin
          state_d      = S_RESP;
          timeout_fire = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Outstanding-cycle counter: cleared on accept, counts while a command is in flight.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (busy)   cnt_q <= cnt_q + CW'(1);
  end

  // Latch the command payload so the AXI address/data stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // AW and W valids rise together after a write accept and drop independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else if (accept) begin
      aw_pend_q <= (cmd_op == 2'b00);
      w_pend_q  <= (cmd_op == 2'b00);
    end else if (timeout_fire) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      if (m_axi_awready) aw_pend_q <= 1'b0;
      if (m_axi_wready)  w_pend_q  <= 1'b0;
    end
  end

  // Response payload: captured from B/R, forced on reserved op or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else if (accept) begin
      rdata_q   <= '0;
      resp_q    <= (cmd_op == 2'b11) ? 2'b10 : 2'b00;
      timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b1;
    end else if ((state_q == S_WR_RESP) && m_axi_bvalid) begin
      resp_q <= m_axi_bresp;
    end else if ((state_q == S_RD_DATA) && m_axi_rvalid) begin
      rdata_q <= m_axi_rdata;
      resp_q  <= m_axi_rresp;
    end
  end

  // Sticky hung flag: a timed-out slave may still answer later, so stop issuing.
  always_ff @(posedge clk) begin
    if (rst)               hung_q <= 1'b0;
    else if (timeout_fire) hung_q <= 1'b1;
  end

  assign cmd_ready     = (state_q == S_IDLE) & ~hung_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign hung          = hung_q;

  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_arvalid = (state_q == S_RD_ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == S_RD_DATA);

  assign state_dbg     = state_q;

endmodule

// File: tb/tb_crf_lite_master.sv
// Directed bench for crf_lite_master. Main instance uses the default timeout;
// a second instance with TIMEOUT_CYCLES=16 and a dead read slave covers abort.
module tb_crf_lite_master;

  logic        clk = 1'b0;
  logic        rst;

  // shared command payload
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  // main instance
  logic        cmd_valid, cmd_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, hung;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        irq;
  logic [2:0]  state_dbg;

  // timeout instance (slave never answers)
  logic        t_cmd_valid, t_cmd_ready;
  logic        t_rsp_valid, t_rsp_ready;
  logic [31:0] t_rsp_rdata;
  logic [1:0]  t_rsp_resp;
  logic        t_rsp_timeout, t_hung;
  logic        t_awvalid, t_wvalid, t_bready, t_arvalid, t_rready;
  logic [31:0] t_awaddr, t_wdata, t_araddr;
  logic [2:0]  t_awprot, t_arprot;
  logic [3:0]  t_wstrb;
  logic [2:0]  t_state_dbg;
  logic        z1 = 1'b0;
  logic [1:0]  z2 = 2'b00;
  logic [31:0] z32 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  crf_lite_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .hung(hung),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp),
    .interrupt_updone(irq), .state_dbg(state_dbg)
  );

  crf_lite_master #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_rdata(t_rsp_rdata),
    .rsp_resp(t_rsp_resp), .rsp_timeout(t_rsp_timeout), .hung(t_hung),
    .m_axi_awvalid(t_awvalid), .m_axi_awready(z1), .m_axi_awaddr(t_awaddr),
    .m_axi_awprot(t_awprot),
    .m_axi_wvalid(t_wvalid), .m_axi_wready(z1), .m_axi_wdata(t_wdata),
    .m_axi_wstrb(t_wstrb),
    .m_axi_bvalid(z1), .m_axi_bready(t_bready), .m_axi_bresp(z2),
    .m_axi_arvalid(t_arvalid), .m_axi_arready(z1), .m_axi_araddr(t_araddr),
    .m_axi_arprot(t_arprot),
    .m_axi_rvalid(z1), .m_axi_rready(t_rready), .m_axi_rdata(z32),
    .m_axi_rresp(z2),
    .interrupt_updone(z1), .state_dbg(t_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
  endtask

  // Issue a command on the main instance; returns one negedge after accept.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Zero-wait write: rsp_valid must show at accept+3.
  task automatic write_zero_wait(input logic [31:0] a, input logic [31:0] d);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    issue(2'b00, a, d);
    check("zw_awvalid_c1", awvalid, 1'b1);
    check("zw_wvalid_c1", wvalid, 1'b1);
    check("zw_awaddr", awaddr, a);
    check("zw_wdata", wdata, d);
    check("zw_wstrb", wstrb, 4'hF);
    check("zw_awprot", awprot, 3'b000);
    check("zw_bready_c1", bready, 1'b0);
    @(negedge clk);
    check("zw_awvalid_c2", awvalid, 1'b0);
    check("zw_wvalid_c2", wvalid, 1'b0);
    check("zw_bready_c2", bready, 1'b1);
    check("zw_rsp_valid_c2", rsp_valid, 1'b0);
    @(negedge clk);
    check("zw_rsp_valid_c3", rsp_valid, 1'b1);
    check("zw_rsp_resp", rsp_resp, 2'b00);
    check("zw_rsp_rdata", rsp_rdata, 32'h0);
    check("zw_rsp_timeout", rsp_timeout, 1'b0);
    check("zw_bready_c3", bready, 1'b0);
    slave_idle();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("zw_rsp_valid_after", rsp_valid, 1'b0);
    check("zw_cmd_ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; irq = 1'b0; t_cmd_valid = 1'b0; t_rsp_ready = 1'b0;
    slave_idle();
    repeat (2) @(negedge clk);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_hung", hung, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // 1: zero-wait write of 1 to 0x00
    write_zero_wait(32'h0000_0000, 32'h0000_0001);

    // 2: awready delayed 3 cycles, wready immediate, bresp=SLVERR
    awready = 1'b0; wready = 1'b1;
    issue(2'b00, 32'h0000_0008, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      check("dw_awvalid_held", awvalid, 1'b1);
      check("dw_wvalid", wvalid, (i == 0));
      check("dw_awaddr_stable", awaddr, 32'h0000_0008);
      if (i == 3) awready = 1'b1;
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0;
    check("dw_awvalid_dropped", awvalid, 1'b0);
    check("dw_bready", bready, 1'b1);
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    check("dw_rsp_valid", rsp_valid, 1'b1);
    check("dw_rsp_resp", rsp_resp, 2'b10);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // 3: read 0x04, rvalid 2 cycles after RD_DATA entry
    arready = 1'b1;
    issue(2'b01, 32'h0000_0004, 32'h0);
    check("rd_arvalid", arvalid, 1'b1);
    check("rd_araddr", araddr, 32'h0000_0004);
    check("rd_arprot", arprot, 3'b000);
    check("rd_rready_in_addr", rready, 1'b0);
    @(negedge clk);
    arready = 1'b0;
    check("rd_arvalid_dropped", arvalid, 1'b0);
    check("rd_rready_1", rready, 1'b1);
    @(negedge clk);
    check("rd_rready_2", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_resp", rsp_resp, 2'b00);
    check("rd_rready_resp", rready, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // 4: wait-for-interrupt, irq rises 50 cycles later, response held 5 cycles
    issue(2'b10, 32'h0, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 49; i++) begin
      if (rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check("irq_no_early_rsp", bad, 1'b0);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("irq_rsp_valid_held", rsp_valid, 1'b1);
      check("irq_rsp_timeout", rsp_timeout, 1'b0);
      check("irq_rsp_resp", rsp_resp, 2'b00);
      check("irq_rsp_rdata", rsp_rdata, 32'h0);
      check("irq_cmd_ready", cmd_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("irq_back_idle", cmd_ready, 1'b1);

    // 5: reserved op answers SLVERR with no bus activity
    issue(2'b11, 32'h0000_0020, 32'h0);
    check("rsv_rsp_valid", rsp_valid, 1'b1);
    check("rsv_rsp_resp", rsp_resp, 2'b10);
    check("rsv_awvalid", awvalid, 1'b0);
    check("rsv_arvalid", arvalid, 1'b0);
    check("rsv_timeout", rsp_timeout, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // 6: timeout (TIMEOUT_CYCLES=16) with arready stuck low
    cmd_op = 2'b01; cmd_addr = 32'h0000_000C; t_cmd_valid = 1'b1;
    check("to_cmd_ready", t_cmd_ready, 1'b1);
    @(negedge clk);
    t_cmd_valid = 1'b0;
    n = 0;
    while (t_arvalid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_arvalid_cycles", n, 16);
    check("to_rsp_valid", t_rsp_valid, 1'b1);
    check("to_rsp_timeout", t_rsp_timeout, 1'b1);
    check("to_rsp_rdata", t_rsp_rdata, 32'h0);
    check("to_rsp_resp", t_rsp_resp, 2'b00);
    check("to_hung", t_hung, 1'b1);
    check("to_rready", t_rready, 1'b0);
    t_rsp_ready = 1'b1;
    @(negedge clk);
    t_rsp_ready = 1'b0;
    check("to_rsp_valid_done", t_rsp_valid, 1'b0);
    t_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("to_cmd_blocked", t_cmd_ready, 1'b0);
      check("to_no_arvalid", t_arvalid, 1'b0);
      @(negedge clk);
    end
    check("to_still_idle", t_state_dbg, 3'd0);
    t_cmd_valid = 1'b0;

    // 7: reset while awvalid is high, then a normal write
    awready = 1'b0; wready = 1'b0;
    issue(2'b00, 32'h0000_0010, 32'hCAFE_0000);
    check("mr_awvalid_before", awvalid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_awvalid", awvalid, 1'b0);
    check("mr_wvalid", wvalid, 1'b0);
    check("mr_rsp_valid", rsp_valid, 1'b0);
    check("mr_state", state_dbg, 3'd0);
    check("mr_t_hung_cleared", t_hung, 1'b0);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || awvalid !== 1'b0) bad = 1'b1;
    end
    check("mr_quiet_after", bad, 1'b0);
    check("mr_t_cmd_ready", t_cmd_ready, 1'b1);
    write_zero_wait(32'h0000_0010, 32'hA5A5_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crf_lite_master.md
Name: crf_lite_master

Overview:
- AXI4-Lite initiator that drives the config register file's AXI-Lite slave port. It sits on the bench/SoC side and programs CRF registers (for example, the UPSTART bit), reads status back, and waits for interrupt_updone.
- Software or a sequencer issues one command at a time over a valid/ready command port. The block runs the AXI-Lite handshakes and returns one response per command.
- A per-command timeout prevents a hung slave from stalling the caller.

Parameters:
AXI_DATA_WIDTH  32  AXI-Lite data width; wstrb is AXI_DATA_WIDTH/8 bits
AXI_ADDR_WIDTH  32  AXI-Lite address width
TIMEOUT_CYCLES  1024  cycles a command may stay outstanding before abort; must be >=2

Ports:
clk  in  1  clock (only clock)
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00=write, 01=read, 10=wait-for-interrupt, 11=reserved
cmd_addr  in  AXI_ADDR_WIDTH  register byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for non-read or timeout)
rsp_resp  out  2  BRESP/RRESP of completed transfer; 00 for irq-wait
rsp_timeout  out  1  command aborted by timeout
hung  out  1  sticky; set on any timeout
m_axi_awvalid/awready/awaddr[AXI_ADDR_WIDTH]/awprot[3]  out/in/out/out  write address channel
m_axi_wvalid/wready/wdata[AXI_DATA_WIDTH]/wstrb[AXI_DATA_WIDTH/8]  out/in/out/out  write data channel
m_axi_bvalid/bready/bresp[2]  in/out/in  write response channel
m_axi_arvalid/arready/araddr[AXI_ADDR_WIDTH]/arprot[3]  out/in/out/out  read address channel
m_axi_rvalid/rready/rdata[AXI_DATA_WIDTH]/rresp[2]  in/out/in/in  read data channel
interrupt_updone  in  1  level interrupt from CRF

Behaviour:
- Reset values: all valids and readies 0, rsp_* 0, hung 0, state IDLE, timeout counter 0.
- Reset asserted mid-transaction drops every output to its reset value at the next edge. No completion is reported.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, WAIT_IRQ, RESP.
- cmd_ready = (state==IDLE) & ~hung. It is combinational from state and hung only, not from cmd_valid.
- IDLE, on accept:
  - Latch addr and wdata.
  - op 00 -> WR; 01 -> RD_ADDR; 10 -> WAIT_IRQ.
  - op 11 -> RESP with rsp_resp=10 and no AXI activity.
- WR:
  - awvalid and wvalid both rise the cycle after accept.
  - Each drops independently on its own handshake; both handshakes may land in the same cycle.
  - When both are done, go to WR_RESP. bready=1 only in WR_RESP.
  - On bvalid, capture bresp and go to RESP.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RESP.
- WAIT_IRQ:
  - On interrupt_updone=1, go to RESP with rsp_resp=00.
  - If the interrupt is already high at entry, RESP follows the next cycle.
- Fixed AXI outputs: awprot=arprot=000, wstrb=all ones, awaddr/araddr/wdata = latched values. Address and data stay stable while the corresponding valid is high.
- AXI rule: a valid, once raised, is never dropped before its handshake, except on timeout or reset.
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready, then IDLE. A new command may be accepted at the earliest one cycle after the rsp handshake.
- Minimum latency with a zero-wait slave: accept at edge N, AW/W handshake N+1, B handshake N+2, rsp_valid at N+3.
- Timeout counter:
  - Clears on accept and increments every cycle in WR, WR_RESP, RD_ADDR, RD_DATA and WAIT_IRQ.
  - If the counter reaches TIMEOUT_CYCLES-1 without completion, all AXI valids/readies drop next cycle and the FSM goes to RESP with rsp_timeout=1, rsp_rdata=0, rsp_resp=00.
  - hung is then set and stays set until reset, holding cmd_ready at 0. This prevents a stale slave response from being matched to a later command.
- Completion and timeout in the same cycle: completion wins, rsp_timeout=0.
- Bus inputs arriving in an unexpected state (bvalid outside WR_RESP, rvalid outside RD_DATA) are ignored.

Test Plan:
- Write 0x0000_0001 to addr 0x00, slave zero-wait -> awaddr=0x00, wdata=1, wstrb=0xF for exactly one cycle each; rsp_valid at accept+3; rsp_resp=00, rsp_rdata=0.
- Write with awready delayed 3 cycles, wready immediate, then bresp=10 -> wvalid drops after 1 cycle, awvalid held 4 cycles; rsp_resp=10.
- Read addr 0x04, slave returns rdata=0xDEAD_BEEF, rresp=00 after 2-cycle rvalid delay -> rsp_rdata=0xDEADBEEF; rready high only in RD_DATA.
- Wait-for-interrupt with interrupt_updone raised 50 cycles later -> rsp_valid 1 cycle after the rise; rsp_timeout=0. Hold rsp_ready low 5 cycles -> rsp fields stable, cmd_ready=0.
- TIMEOUT_CYCLES=16, read with arready stuck 0 -> arvalid drops at cycle 16; rsp_timeout=1; hung=1; a further cmd_valid is never accepted until rst.
- Reset pulse while awvalid=1 -> awvalid=0 next edge; no rsp_valid; the next write completes normally.
